// File: rtl/ape_mem_resp.sv
// Word-addressed SRAM responder for the APE core request/response port.
// Latency: LATENCY cycles from grant to r_valid_o. Backpressure: none on responses; grant is withheld only while a backdoor write is active.
// Error responses (misaligned or out of range) return zero data and increment a saturating counter.
module ape_mem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_i,
    input  logic [31:0]                    add_i,
    output logic                           gnt_o,
    output logic [31:0]                    r_rdata_o,
    output logic                           r_valid_o,
    output logic                           r_opc_o,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
    input  logic [31:0]                    wdata_i,
    output logic                           err_valid_o,
    output logic [15:0]                    err_cnt_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic             accept;
    logic             addr_err;
    logic [AW-1:0]    word_idx;
    logic [31:0]      rd_dat;

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] opc_q;
    logic [31:0]        dat_q [LATENCY];

    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_valid_q;

    assign gnt_o    = req_i & ~we_i;
    assign accept   = req_i & gnt_o;
    assign word_idx = add_i[2 +: AW];
    assign addr_err = (add_i[1:0] != 2'b00) | (|add_i[31:AW+2]);
    // Data is zeroed at entry so the output never needs a qualifying mux.
    assign rd_dat   = (accept & ~addr_err) ? mem_q[word_idx] : 32'h0;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            opc_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= 32'h0;
            end
        end else begin
            vld_q[0] <= accept;
            opc_q[0] <= accept & addr_err;
            dat_q[0] <= rd_dat;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                opc_q[i] <= opc_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign r_valid_o = vld_q[LATENCY-1];
    assign r_opc_o   = opc_q[LATENCY-1];
    assign r_rdata_o = dat_q[LATENCY-1];

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (r_valid_o && r_opc_o && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q   <= 16'h0;
            err_valid_q <= 1'b0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            err_valid_q <= (err_cnt_q != 16'h0);
        end
    end

    assign err_cnt_o   = err_cnt_q;
    assign err_valid_o = err_valid_q;

endmodule

// File: tb/tb_ape_mem_resp.sv
// Bench for ape_mem_resp: four instances (LATENCY 1..4) share one stimulus stream and are
// checked every cycle against a cycle-indexed response history plus literal spot checks.
module tb_ape_mem_resp;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [9:0]  waddr;
    logic [31:0] wdata;

    logic        gnt      [4];
    logic [31:0] r_rdata  [4];
    logic        r_valid  [4];
    logic        r_opc    [4];
    logic        err_valid[4];
    logic [15:0] err_cnt  [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ape_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(g + 1)) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .req_i      (req),
            .add_i      (add),
            .gnt_o      (gnt[g]),
            .r_rdata_o  (r_rdata[g]),
            .r_valid_o  (r_valid[g]),
            .r_opc_o    (r_opc[g]),
            .we_i       (we),
            .waddr_i    (waddr),
            .wdata_i    (wdata),
            .err_valid_o(err_valid[g]),
            .err_cnt_o  (err_cnt[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: history of accepted requests, indexed by edge number ----------
    logic [31:0] mem_m [DEPTH];
    bit          hv [8];
    bit          ho [8];
    logic [31:0] hd [8];
    int          cyc = 0;
    int          err_m  [4];
    bit          errv_m [4];

    function automatic int slot(input int c, input int l);
        return (c - l + 1) & 7;
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) begin hv[i] = 0; ho[i] = 0; hd[i] = 0; end
        for (int k = 0; k < 4; k++) begin err_m[k] = 0; errv_m[k] = 0; end
    end

    always @(posedge clk) begin
        int s;
        int ns;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) hv[i] = 0;
            for (int k = 0; k < 4; k++) begin err_m[k] = 0; errv_m[k] = 0; end
        end else begin
            for (int k = 0; k < 4; k++) begin
                s = slot(cyc, k + 1);
                errv_m[k] = (err_m[k] != 0);
                if (hv[s] && ho[s] && err_m[k] < 65535) err_m[k] = err_m[k] + 1;
            end
        end
        cyc = cyc + 1;
        ns = cyc & 7;
        hv[ns] = 0; ho[ns] = 0; hd[ns] = 32'h0;
        if (rst_n && req && !we) begin
            hv[ns] = 1;
            ho[ns] = (add % 4 != 0) || ((add / 4) >= DEPTH);
            hd[ns] = ho[ns] ? 32'h0 : mem_m[add / 4];
        end
        if (we) mem_m[waddr] = wdata;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int s;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("gnt_L%0d", k + 1), 32'(gnt[k]), 32'(req & ~we));
            if (!rst_n) begin
                chk($sformatf("rst_vld_L%0d", k + 1), 32'(r_valid[k]), 32'd0);
                chk($sformatf("rst_opc_L%0d", k + 1), 32'(r_opc[k]), 32'd0);
                chk($sformatf("rst_dat_L%0d", k + 1), r_rdata[k], 32'd0);
                chk($sformatf("rst_cnt_L%0d", k + 1), 32'(err_cnt[k]), 32'd0);
                chk($sformatf("rst_ev_L%0d", k + 1), 32'(err_valid[k]), 32'd0);
            end else begin
                s = slot(cyc, k + 1);
                chk($sformatf("vld_L%0d", k + 1), 32'(r_valid[k]), 32'(hv[s]));
                chk($sformatf("opc_L%0d", k + 1), 32'(r_opc[k]), 32'(hv[s] & ho[s]));
                chk($sformatf("dat_L%0d", k + 1), r_rdata[k], hv[s] ? hd[s] : 32'h0);
                chk($sformatf("cnt_L%0d", k + 1), 32'(err_cnt[k]), 32'(err_m[k]));
                chk($sformatf("ev_L%0d", k + 1), 32'(err_valid[k]), 32'(errv_m[k]));
            end
        end
    end

    int post_rst_pulses = 0;
    bit watch_pulses    = 0;
    always @(negedge clk) begin
        if (watch_pulses) begin
            for (int k = 0; k < 4; k++) if (r_valid[k]) post_rst_pulses++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; req = 1'b0; add = 32'h0; we = 1'b0; waddr = '0; wdata = 32'h0;
        step(); step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("init_vld_L%0d", k + 1), 32'(r_valid[k]), 32'd0);
            chk($sformatf("init_cnt_L%0d", k + 1), 32'(err_cnt[k]), 32'd0);
        end
        rst_n = 1'b1;
        step();

        // Preload every word so random reads have a defined value.
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; waddr = 10'(i); wdata = 32'(i) * 32'h9E3779B1;
            step();
        end
        we = 1'b0;

        // Backdoor load then back-to-back reads.
        we = 1'b1; waddr = 10'd5; wdata = 32'hDEADBEEF; step();
        waddr = 10'd6; wdata = 32'h12345678; step();
        we = 1'b0;
        req = 1'b1; add = 32'h14; step();
        chk("bd_l1_vld0", 32'(r_valid[0]), 32'd1);
        chk("bd_l1_dat0", r_rdata[0], 32'hDEADBEEF);
        add = 32'h18; step();
        chk("bd_l1_dat1", r_rdata[0], 32'h12345678);
        chk("bd_l2_vld0", 32'(r_valid[1]), 32'd1);
        chk("bd_l2_dat0", r_rdata[1], 32'hDEADBEEF);
        req = 1'b0; step();
        chk("bd_l2_dat1", r_rdata[1], 32'h12345678);
        chk("bd_l2_opc1", 32'(r_opc[1]), 32'd0);
        chk("bd_l1_idle", 32'(r_valid[0]), 32'd0);
        repeat (4) step();

        // Misaligned and out-of-range requests.
        req = 1'b1; add = 32'h15; step();
        chk("err_l1_opc", 32'(r_opc[0]), 32'd1);
        chk("err_l1_dat", r_rdata[0], 32'h0);
        add = DEPTH * 4; step();
        chk("err_l1_opc2", 32'(r_opc[0]), 32'd1);
        req = 1'b0;
        repeat (6) step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("err_cnt2_L%0d", k + 1), 32'(err_cnt[k]), 32'd2);
            chk($sformatf("err_ev_L%0d", k + 1), 32'(err_valid[k]), 32'd1);
        end

        // Backdoor write collides with a request.
        we = 1'b1; waddr = 10'd7; wdata = 32'hA5A5A5A5; req = 1'b1; add = 32'h1C;
        #1;
        chk("prio_gnt0", 32'(gnt[0]), 32'd0);
        step();
        we = 1'b0;
        #1;
        chk("prio_gnt1", 32'(gnt[0]), 32'd1);
        step();
        chk("prio_dat", r_rdata[0], 32'hA5A5A5A5);
        req = 1'b0;
        repeat (4) step();

        // Write to a word with a read in flight.
        we = 1'b1; waddr = 10'd3; wdata = 32'h1; step();
        we = 1'b0; req = 1'b1; add = 32'hC; step();
        req = 1'b0; we = 1'b1; waddr = 10'd3; wdata = 32'h2; step();
        we = 1'b0;
        chk("inflight_l2", r_rdata[1], 32'h1);
        step(); step();
        chk("inflight_l4", r_rdata[3], 32'h1);
        repeat (4) step();

        // Reset with three requests in flight.
        req = 1'b1; add = 32'h20; step();
        add = 32'h24; step();
        add = 32'h3; step();
        req = 1'b0; rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mrst_vld_L%0d", k + 1), 32'(r_valid[k]), 32'd0);
            chk($sformatf("mrst_dat_L%0d", k + 1), r_rdata[k], 32'd0);
            chk($sformatf("mrst_cnt_L%0d", k + 1), 32'(err_cnt[k]), 32'd0);
        end
        step(); step();
        rst_n = 1'b1;
        watch_pulses = 1'b1;
        repeat (8) step();
        watch_pulses = 1'b0;
        chk("post_rst_pulses", 32'(post_rst_pulses), 32'd0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("post_rst_cnt_L%0d", k + 1), 32'(err_cnt[k]), 32'd0);

        // Random back-to-back traffic with occasional writes and errors.
        for (int i = 0; i < 100; i++) begin
            req = 1'b1;
            if ($urandom_range(7) == 0) add = $urandom() | 32'h1000;
            else add = {20'h0, 10'($urandom_range(DEPTH - 1)), 2'b00};
            we = ($urandom_range(9) == 0);
            waddr = 10'($urandom_range(DEPTH - 1));
            wdata = $urandom();
            step();
        end
        req = 1'b0; we = 1'b0;
        repeat (6) step();

        // Saturate the error counter.
        req = 1'b1; add = 32'h3;
        repeat (70000) step();
        req = 1'b0;
        repeat (6) step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sat_cnt_L%0d", k + 1), 32'(err_cnt[k]), 32'h0000FFFF);
            chk($sformatf("sat_ev_L%0d", k + 1), 32'(err_valid[k]), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ape_mem_resp.md
# ape_mem_resp

Memory-side responder for the APE core request/response interface (`req`/`add` in; `gnt`/`r_rdata`/`r_valid`/`r_opc` out). Holds a word-addressed on-chip SRAM model that answers core fetch and load requests in order with a fixed, parameterised latency. A backdoor write port loads and patches contents. A saturating error counter reports rejected addresses. It sits between the APE core's memory port and the instruction/data storage and serves as synthesizable memory and bench target.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, 16..65536.
- `LATENCY`, 2: cycles from accepted request to `r_valid_o`; legal 1..4.
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  core request valid.
- `add_i`  in  32  byte address, valid while `req_i`.
- `gnt_o`  out  1  request accepted this cycle (combinational).
- `r_rdata_o`  out  32  response read data.
- `r_valid_o`  out  1  response valid, one-cycle pulse per accepted request.
- `r_opc_o`  out  1  response error flag, qualified by `r_valid_o`.
- `we_i`  in  1  backdoor write enable.
- `waddr_i`  in  log2(DEPTH_WORDS)  backdoor word index.
- `wdata_i`  in  32  backdoor write data.
- `err_valid_o`  out  1  high once `err_cnt_o` is nonzero.
- `err_cnt_o`  out  16  saturating count of error responses.

## Operation
- Grant: `gnt_o = req_i & ~we_i`. Backdoor write has strict priority and blocks grant for that cycle. The core holds `req_i`/`add_i` until granted.
- Accept (`req_i & gnt_o`): classify the address.
  - Error if `add_i[1:0] != 0` (misaligned).
  - Error if `add_i[31:2] >= DEPTH_WORDS` (out of range).
  - Otherwise read word `add_i[2 +: log2(DEPTH_WORDS)]`.
- SRAM is read in the acceptance cycle. Data, the valid bit and the error bit then travel through a LATENCY-deep shift pipeline. Pipeline bits are cleared on reset; SRAM contents are not reset.
- Response: `r_valid_o` asserts for exactly one cycle per accepted request, in acceptance order. There is no response backpressure.
  - Error response: `r_opc_o=1`, `r_rdata_o=0`.
  - Good response: `r_opc_o=0`, `r_rdata_o` = word value at acceptance.
- When `r_valid_o=0`: `r_rdata_o=0` and `r_opc_o=0`.
- Backdoor write: when `we_i`, `mem[waddr_i] <= wdata_i` at the clock edge.
- Ordering: a write to a word that has an in-flight read does not alter that read; the read returns the pre-write value.
- Error counter: increments by one on each error response (at `r_valid_o & r_opc_o`) and saturates at 0xFFFF. It is cleared only by reset. `err_valid_o = (err_cnt_o != 0)`, registered.

## Timing
- Reset (`rst_ni` low, async) forces:
  - `r_valid_o=0`, `r_opc_o=0`, `r_rdata_o=0`, `err_cnt_o=0`, `err_valid_o=0`.
  - All pipeline valid bits to 0.
- `gnt_o` is combinational. While reset is asserted it is still `req_i & ~we_i`, but no request is accepted.
- A request accepted at edge t gives `r_valid_o` high in the cycle after edge t+LATENCY-1. With LATENCY=1, that is the cycle immediately following acceptance.
- Throughput: one request per cycle sustained. Back-to-back grants produce back-to-back `r_valid_o` pulses with no bubbles.
- Reset mid-operation: all in-flight responses are dropped with no `r_valid_o` pulse, even after deassertion. The first response after reset comes only from a post-reset acceptance.
- `err_cnt_o` updates at the edge ending the error response cycle. `err_valid_o` rises one cycle after the counter first becomes nonzero.
- Simultaneous `we_i` and `req_i`: the write commits, the request is not granted, and it is accepted the next cycle if `we_i` is low. It then sees the new data, even for the same address.

## Test plan
- Backdoor load: write 0xDEADBEEF to word 5 and 0x12345678 to word 6, then request 0x14 and 0x18 back-to-back. Require:
  - two grants;
  - `r_valid_o` pulses at acceptance+LATENCY, consecutive;
  - data 0xDEADBEEF then 0x12345678, `r_opc_o=0`.
- Errors: request 0x15 (misaligned), then DEPTH_WORDS*4 (out of range). Require two responses with `r_opc_o=1`, `r_rdata_o=0`; `err_cnt_o=2`; `err_valid_o=1`.
- Priority: assert `we_i` (word 7 = 0xA5A5A5A5) in the same cycle as `req_i` for 0x1C. Require `gnt_o=0` that cycle, a grant next cycle, and response data 0xA5A5A5A5.
- In-flight write: accept a read of word 3 (holding 0x1), then backdoor-write 0x2 to word 3 the next cycle. Require the response to be 0x1.
- Reset mid-flight: accept 3 requests, then pulse `rst_ni` low before any response. Require:
  - no `r_valid_o` pulses afterward;
  - all outputs 0 during reset;
  - `err_cnt_o=0`.
- Sweep LATENCY 1..4 with 100 random back-to-back requests. Require in-order responses at exact latency, and `err_cnt_o` saturation at 0xFFFF when forced via 70000 error requests.
